// File: rtl/dm_pkg.sv
// Shared types and sberror codes for the debug module system bus access lane.
package dm_pkg;

  typedef enum logic [2:0] {
    SbaIdle,
    SbaRead,
    SbaWrite,
    SbaWaitRead,
    SbaWaitWrite
  } sba_state_e;

  localparam logic [2:0] SbErrNone    = 3'd0;
  localparam logic [2:0] SbErrTimeout = 3'd1;
  localparam logic [2:0] SbErrBadAddr = 3'd2;
  localparam logic [2:0] SbErrAlign   = 3'd3;
  localparam logic [2:0] SbErrSize    = 3'd4;
  localparam logic [2:0] SbErrOther   = 3'd7;

endpackage

// File: rtl/dm_sba_lane_align.sv
// Byte-lane steering for one bus beat: byte enables, write-data shift, read-data extract.
module dm_sba_lane_align #(
  parameter int unsigned BusWidth = 32
) (
  input  logic [$clog2(BusWidth/8)-1:0] lane_i,
  input  logic [2:0]                    size_i,
  input  logic [BusWidth-1:0]           wdata_i,
  input  logic [BusWidth-1:0]           rdata_i,
  output logic [BusWidth/8-1:0]         be_o,
  output logic [BusWidth-1:0]           wdata_o,
  output logic [BusWidth-1:0]           rdata_o
);

  localparam int unsigned NumBytes = BusWidth / 8;

  logic [BusWidth-1:0] w_rd_shift;

  assign wdata_o    = wdata_i << {lane_i, 3'b000};
  assign w_rd_shift = rdata_i >> {lane_i, 3'b000};

  always_comb begin
    be_o    = '0;
    rdata_o = '0;
    for (int i = 0; i < NumBytes; i++) begin
      be_o[i] = (i >= int'(lane_i)) && (i < int'(lane_i) + (32'sd1 <<< size_i));
      if (i < (32'sd1 <<< size_i)) begin
        rdata_o[8*i +: 8] = w_rd_shift[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/dm_sba_lane.sv
// System bus access master: checks, issues and completes one single-beat access per trigger.
// Optional response timeout is enabled by defining DM_SBA_TIMEOUT_EN.
module dm_sba_lane
  import dm_pkg::*;
#(
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned BusWidth       = 32,
  parameter bit          ReadByteEnable = 1'b1,
  parameter int unsigned TimeoutCycles  = 1024
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  dmactive_i,
  output logic                  master_req_o,
  output logic [AddrWidth-1:0]  master_add_o,
  output logic                  master_we_o,
  output logic [BusWidth-1:0]   master_wdata_o,
  output logic [BusWidth/8-1:0] master_be_o,
  input  logic                  master_gnt_i,
  input  logic                  master_r_valid_i,
  input  logic                  master_r_err_i,
  input  logic                  master_r_other_err_i,
  input  logic [BusWidth-1:0]   master_r_rdata_i,
  input  logic [AddrWidth-1:0]  sbaddress_i,
  input  logic                  sbaddress_write_valid_i,
  input  logic                  sbreadonaddr_i,
  input  logic                  sbautoincrement_i,
  input  logic [2:0]            sbaccess_i,
  input  logic                  sbreadondata_i,
  input  logic [BusWidth-1:0]   sbdata_i,
  input  logic                  sbdata_read_valid_i,
  input  logic                  sbdata_write_valid_i,
  output logic [AddrWidth-1:0]  sbaddress_o,
  output logic                  sbaddress_update_o,
  output logic [BusWidth-1:0]   sbdata_o,
  output logic                  sbdata_valid_o,
  output logic                  sbbusy_o,
  output logic                  sbbusyerror_o,
  output logic                  sberror_valid_o,
  output logic [2:0]            sberror_o
);

  localparam int unsigned LaneBits  = $clog2(BusWidth / 8);
  localparam logic [2:0]  MaxAccess = 3'(LaneBits);

  sba_state_e            r_state;
  logic [BusWidth-1:0]   r_sbdata;
  logic                  r_sbdata_vld;

  logic                  w_rd_trig, w_wr_trig, w_trig, w_idle, w_wait;
  logic                  w_size_err, w_align_err, w_rsp, w_rsp_err, w_tmo;
  logic [BusWidth/8-1:0] w_be;
  logic [BusWidth-1:0]   w_rdata;

  assign w_rd_trig = (sbaddress_write_valid_i & sbreadonaddr_i) | (sbdata_read_valid_i & sbreadondata_i);
  assign w_wr_trig = sbdata_write_valid_i;
  assign w_trig    = w_rd_trig | w_wr_trig;
  assign w_idle    = (r_state == SbaIdle);
  assign w_wait    = (r_state == SbaWaitRead) || (r_state == SbaWaitWrite);
  assign w_rsp     = w_wait & master_r_valid_i;
  assign w_rsp_err = master_r_err_i | master_r_other_err_i;
  assign w_size_err = sbaccess_i > MaxAccess;

  always_comb begin
    w_align_err = 1'b0;
    for (int i = 0; i < LaneBits; i++) begin
      if (i < int'(sbaccess_i) && sbaddress_i[i]) w_align_err = 1'b1;
    end
  end

  dm_sba_lane_align #(.BusWidth(BusWidth)) u_align (
    .lane_i  (sbaddress_i[LaneBits-1:0]),
    .size_i  (sbaccess_i),
    .wdata_i (sbdata_i),
    .rdata_i (master_r_rdata_i),
    .be_o    (w_be),
    .wdata_o (master_wdata_o),
    .rdata_o (w_rdata)
  );

`ifdef DM_SBA_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TimeoutCycles);
  logic [TmoW-1:0] r_tmo_cnt;

  assign w_tmo = w_wait && !master_r_valid_i && (r_tmo_cnt == TmoW'(TimeoutCycles - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_tmo_cnt <= '0;
    end else if (!dmactive_i || !w_wait || w_rsp || w_tmo) begin
      r_tmo_cnt <= '0;
    end else begin
      r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end
  end
`else
  assign w_tmo = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state      <= SbaIdle;
      r_sbdata     <= '0;
      r_sbdata_vld <= 1'b0;
    end else if (!dmactive_i) begin
      r_state      <= SbaIdle;
      r_sbdata     <= '0;
      r_sbdata_vld <= 1'b0;
    end else begin
      r_sbdata_vld <= 1'b0;
      case (r_state)
        SbaIdle: begin
          if (w_trig && !w_size_err && !w_align_err) begin
            r_state <= w_wr_trig ? SbaWrite : SbaRead;
          end
        end
        SbaRead:  if (master_gnt_i) r_state <= SbaWaitRead;
        SbaWrite: if (master_gnt_i) r_state <= SbaWaitWrite;
        SbaWaitRead: begin
          if (master_r_valid_i) begin
            r_sbdata     <= w_rdata;
            r_sbdata_vld <= 1'b1;
            r_state      <= SbaIdle;
          end else if (w_tmo) begin
            r_state <= SbaIdle;
          end
        end
        SbaWaitWrite: if (master_r_valid_i || w_tmo) r_state <= SbaIdle;
        default: r_state <= SbaIdle;
      endcase
    end
  end

  // Error precedence: the pre-issue check and the response can never coincide (Idle vs Wait).
  always_comb begin
    sberror_valid_o = 1'b0;
    sberror_o       = SbErrNone;
    if (dmactive_i) begin
      if (w_idle && w_trig && w_size_err) begin
        sberror_valid_o = 1'b1;
        sberror_o       = SbErrSize;
      end else if (w_idle && w_trig && w_align_err) begin
        sberror_valid_o = 1'b1;
        sberror_o       = SbErrAlign;
      end else if (w_rsp && master_r_other_err_i) begin
        sberror_valid_o = 1'b1;
        sberror_o       = SbErrOther;
      end else if (w_rsp && master_r_err_i) begin
        sberror_valid_o = 1'b1;
        sberror_o       = SbErrBadAddr;
      end else if (w_tmo) begin
        sberror_valid_o = 1'b1;
        sberror_o       = SbErrTimeout;
      end
    end
  end

  assign master_req_o       = (r_state == SbaRead) || (r_state == SbaWrite);
  assign master_we_o        = (r_state == SbaWrite);
  assign master_be_o        = (master_we_o || (master_req_o && ReadByteEnable)) ? w_be : '0;
  assign master_add_o       = sbaddress_i;
  assign sbaddress_o        = sbaddress_i + (AddrWidth'(1) << sbaccess_i);
  assign sbaddress_update_o = dmactive_i && w_rsp && sbautoincrement_i && !w_rsp_err;
  assign sbdata_o           = r_sbdata;
  assign sbdata_valid_o     = r_sbdata_vld;
  assign sbbusy_o           = !w_idle;
  assign sbbusyerror_o      = dmactive_i && !w_idle && w_trig;

endmodule

// File: tb/tb_dm_sba_lane.sv
// Randomized bench for dm_sba_lane on a 64-bit bus against an arithmetic reference model.
module tb_dm_sba_lane;

  localparam int AW = 32;
  localparam int BW = 64;
  localparam int NB = BW / 8;
`ifdef DM_SBA_TIMEOUT_EN
  localparam int TC = 8;
`else
  localparam int TC = 1024;
`endif

  logic          clk_i = 1'b0, rst_i = 1'b1, dmactive_i = 1'b0;
  logic          master_req_o, master_we_o, master_gnt_i;
  logic [AW-1:0] master_add_o;
  logic [BW-1:0] master_wdata_o, master_r_rdata_i;
  logic [NB-1:0] master_be_o;
  logic          master_r_valid_i, master_r_err_i, master_r_other_err_i;
  logic [AW-1:0] sbaddress_i, sbaddress_o;
  logic          sbaddress_write_valid_i, sbreadonaddr_i, sbautoincrement_i;
  logic [2:0]    sbaccess_i, sberror_o;
  logic          sbreadondata_i, sbdata_read_valid_i, sbdata_write_valid_i;
  logic [BW-1:0] sbdata_i, sbdata_o;
  logic          sbaddress_update_o, sbdata_valid_o, sbbusy_o, sbbusyerror_o, sberror_valid_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  dm_sba_lane #(.AddrWidth(AW), .BusWidth(BW), .ReadByteEnable(1'b1), .TimeoutCycles(TC)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .dmactive_i(dmactive_i),
    .master_req_o(master_req_o), .master_add_o(master_add_o), .master_we_o(master_we_o),
    .master_wdata_o(master_wdata_o), .master_be_o(master_be_o), .master_gnt_i(master_gnt_i),
    .master_r_valid_i(master_r_valid_i), .master_r_err_i(master_r_err_i),
    .master_r_other_err_i(master_r_other_err_i), .master_r_rdata_i(master_r_rdata_i),
    .sbaddress_i(sbaddress_i), .sbaddress_write_valid_i(sbaddress_write_valid_i),
    .sbreadonaddr_i(sbreadonaddr_i), .sbautoincrement_i(sbautoincrement_i),
    .sbaccess_i(sbaccess_i), .sbreadondata_i(sbreadondata_i), .sbdata_i(sbdata_i),
    .sbdata_read_valid_i(sbdata_read_valid_i), .sbdata_write_valid_i(sbdata_write_valid_i),
    .sbaddress_o(sbaddress_o), .sbaddress_update_o(sbaddress_update_o),
    .sbdata_o(sbdata_o), .sbdata_valid_o(sbdata_valid_o), .sbbusy_o(sbbusy_o),
    .sbbusyerror_o(sbbusyerror_o), .sberror_valid_o(sberror_valid_o), .sberror_o(sberror_o)
  );

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: byte count 2^size placed at lane addr mod 8.
  function automatic logic [NB-1:0] exp_be(input logic [AW-1:0] a, input logic [2:0] sz);
    int n, lane;
    n = 1 << sz;
    lane = int'(a % NB);
    return NB'(((1 << n) - 1) << lane);
  endfunction

  function automatic logic [BW-1:0] exp_rd(input logic [BW-1:0] rd, input logic [AW-1:0] a, input logic [2:0] sz);
    logic [127:0] t;
    t = {64'b0, rd} >> (8 * (a % NB));
    t = t & ((128'd1 << (8 * (1 << sz))) - 128'd1);
    return t[BW-1:0];
  endfunction

  function automatic logic [BW-1:0] exp_wd(input logic [BW-1:0] d, input logic [AW-1:0] a);
    logic [127:0] t;
    t = {64'b0, d} << (8 * (a % NB));
    return t[BW-1:0];
  endfunction

  function automatic logic [BW-1:0] lane_mask(input logic [NB-1:0] be);
    logic [BW-1:0] m;
    m = '0;
    for (int i = 0; i < NB; i++) if (be[i]) m[8*i +: 8] = 8'hFF;
    return m;
  endfunction

  task automatic clear_trig();
    sbdata_write_valid_i    = 1'b0;
    sbaddress_write_valid_i = 1'b0;
    sbdata_read_valid_i     = 1'b0;
  endtask

  task automatic access(input bit wr, input logic [AW-1:0] a, input logic [2:0] sz,
                        input logic [BW-1:0] d, input bit ai, input int gd, input int rd,
                        input bit rerr, input bit oerr, input logic [BW-1:0] rdat, input bit poke);
    int pre, code;
    logic [NB-1:0] be;
    pre = (sz > 3) ? 4 : (((a % (32'd1 << sz)) != 0) ? 3 : 0);
    sbaddress_i = a; sbaccess_i = sz; sbdata_i = d; sbautoincrement_i = ai;
    if (wr) begin
      sbdata_write_valid_i = 1'b1;
      if ($urandom_range(1) == 1) begin sbaddress_write_valid_i = 1'b1; sbreadonaddr_i = 1'b1; end
    end else if ($urandom_range(1) == 1) begin
      sbaddress_write_valid_i = 1'b1; sbreadonaddr_i = 1'b1;
    end else begin
      sbdata_read_valid_i = 1'b1; sbreadondata_i = 1'b1;
    end
    #1;
    chk("pre_err_vld", sberror_valid_o, pre != 0);
    if (pre != 0) chk("pre_err_code", sberror_o, pre);
    @(posedge clk_i); #1;
    clear_trig();
    if (pre != 0) begin
      chk("pre_err_no_req", master_req_o, 0);
      chk("pre_err_no_busy", sbbusy_o, 0);
      return;
    end
    be = exp_be(a, sz);
    for (int i = 0; i <= gd; i++) begin
      chk("req", master_req_o, 1);
      chk("we", master_we_o, wr);
      chk("be", master_be_o, be);
      chk("addr", master_add_o, a);
      if (wr) chk("wdata", master_wdata_o & lane_mask(be), exp_wd(d, a) & lane_mask(be));
      if (i == 0 && gd > 0) begin
        master_r_valid_i = 1'b1; master_r_err_i = 1'b1; #1;
        chk("stray_rsp_ignored", {sberror_valid_o, sbaddress_update_o}, 0);
        master_r_valid_i = 1'b0; master_r_err_i = 1'b0;
      end
      if (i == gd) master_gnt_i = 1'b1;
      @(posedge clk_i); #1;
    end
    master_gnt_i = 1'b0;
    chk("req_drop_after_gnt", master_req_o, 0);
    chk("busy_in_wait", sbbusy_o, 1);
    for (int i = 0; i < rd; i++) begin
      if (poke && i == 0) begin
        sbdata_write_valid_i = 1'b1; #1;
        chk("busyerror", sbbusyerror_o, 1);
        sbdata_write_valid_i = 1'b0;
      end
      @(posedge clk_i); #1;
    end
    master_r_valid_i = 1'b1; master_r_err_i = rerr; master_r_other_err_i = oerr; master_r_rdata_i = rdat;
    #1;
    code = oerr ? 7 : (rerr ? 2 : 0);
    chk("rsp_err_vld", sberror_valid_o, code != 0);
    if (code != 0) chk("rsp_err_code", sberror_o, code);
    chk("addr_update", sbaddress_update_o, ai && code == 0);
    if (ai && code == 0) chk("next_addr", sbaddress_o, AW'(a + (32'd1 << sz)));
    @(posedge clk_i); #1;
    master_r_valid_i = 1'b0; master_r_err_i = 1'b0; master_r_other_err_i = 1'b0;
    chk("idle_after_rsp", sbbusy_o, 0);
    chk("data_vld", sbdata_valid_o, !wr);
    if (!wr) chk("rdata", sbdata_o, exp_rd(rdat, a, sz));
    @(posedge clk_i); #1;
    chk("data_vld_pulse", sbdata_valid_o, 0);
  endtask

  initial begin
    logic [AW-1:0] a;
    logic [2:0]    sz;
    int            rd, found;
    master_gnt_i = 0; master_r_valid_i = 0; master_r_err_i = 0; master_r_other_err_i = 0;
    master_r_rdata_i = '0; sbaddress_i = '0; sbaccess_i = 3'd2; sbdata_i = '0;
    sbreadonaddr_i = 0; sbreadondata_i = 0; sbautoincrement_i = 0; clear_trig();
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_req", master_req_o, 0);
    chk("rst_be", master_be_o, 0);
    chk("rst_busy", sbbusy_o, 0);
    chk("rst_sbdata", sbdata_o, 0);
    chk("rst_pulses", {sbdata_valid_o, sberror_valid_o, sbbusyerror_o, sbaddress_update_o}, 0);
    rst_i = 1'b0; dmactive_i = 1'b1;
    @(posedge clk_i); #1;

    access(1, 32'h1004, 3'd2, 64'hDEADBEEF, 1, 2, 1, 0, 0, 64'h0, 0);
    access(0, 32'h2003, 3'd0, 64'h0, 0, 1, 2, 0, 0, 64'hAB000000, 0);
    access(0, 32'h3001, 3'd1, 64'h0, 0, 0, 0, 0, 0, 64'h0, 0);
    access(1, 32'h3000, 3'd4, 64'h0, 0, 0, 0, 0, 0, 64'h0, 0);
    access(0, 32'h4000, 3'd2, 64'h0, 1, 0, 1, 1, 1, 64'h1234_5678_9ABC_DEF0, 0);
    access(0, 32'h4008, 3'd3, 64'h0, 1, 0, 0, 1, 0, 64'h1, 0);
    access(0, 32'h5010, 3'd3, 64'h0, 0, 0, 2, 0, 0, 64'hCAFE_F00D_0123_4567, 1);
    access(1, 32'hFFFF_FFFC, 3'd2, 64'h55AA_55AA, 1, 0, 0, 0, 0, 64'h0, 0);

    for (int n = 0; n < 60; n++) begin
      sz = ($urandom_range(9) == 0) ? 3'($urandom_range(7, 4)) : 3'($urandom_range(3));
      a = $urandom;
      if (sz <= 3 && $urandom_range(3) != 0) a = a & ~((32'd1 << sz) - 32'd1);
      rd = $urandom_range(4);
      access($urandom_range(1) == 1, a, sz, {$urandom, $urandom}, $urandom_range(1) == 1,
             $urandom_range(3), rd, $urandom_range(5) == 0, $urandom_range(7) == 0,
             {$urandom, $urandom}, rd > 0 && $urandom_range(3) == 0);
    end

    // Asynchronous reset in the middle of a write request.
    sbaddress_i = 32'h6000; sbaccess_i = 3'd2; sbdata_write_valid_i = 1'b1;
    @(posedge clk_i); #1;
    clear_trig();
    chk("mid_write_req", master_req_o, 1);
    #2 rst_i = 1'b1; #1;
    chk("rst_drops_req", master_req_o, 0);
    chk("rst_drops_busy", sbbusy_o, 0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    @(posedge clk_i); #1;

    // dmactive low while waiting for a read response clears state and sbdata.
    access(0, 32'h7000, 3'd3, 64'h0, 0, 0, 0, 0, 0, 64'hFFEE_DDCC_BBAA_9988, 0);
    sbaddress_i = 32'h7000; sbaccess_i = 3'd2; sbaddress_write_valid_i = 1'b1; sbreadonaddr_i = 1'b1;
    @(posedge clk_i); #1;
    clear_trig(); master_gnt_i = 1'b1;
    @(posedge clk_i); #1;
    master_gnt_i = 1'b0; dmactive_i = 1'b0;
    @(posedge clk_i); #1;
    dmactive_i = 1'b1;
    chk("dmactive_clear_busy", sbbusy_o, 0);
    chk("dmactive_clear_data", sbdata_o, 0);
    master_r_valid_i = 1'b1; #1;
    chk("late_rsp_ignored", {sberror_valid_o, sbaddress_update_o}, 0);
    @(posedge clk_i); #1;
    master_r_valid_i = 1'b0;
    chk("late_rsp_no_data", sbdata_valid_o, 0);

`ifdef DM_SBA_TIMEOUT_EN
    sbaddress_i = 32'h8000; sbaccess_i = 3'd2; sbaddress_write_valid_i = 1'b1; sbreadonaddr_i = 1'b1;
    sbautoincrement_i = 1'b1;
    @(posedge clk_i); #1;
    clear_trig(); master_gnt_i = 1'b1;
    @(posedge clk_i); #1;
    master_gnt_i = 1'b0;
    found = -1;
    for (int k = 0; k < 20; k++) begin
      if (sberror_valid_o) begin found = k; break; end
      @(posedge clk_i); #1;
    end
    chk("tmo_cycle", found, TC - 1);
    chk("tmo_code", sberror_o, 1);
    chk("tmo_no_update", sbaddress_update_o, 0);
    @(posedge clk_i); #1;
    chk("tmo_idle", sbbusy_o, 0);
    repeat (2) @(posedge clk_i);
    #1 master_r_valid_i = 1'b1; #1;
    chk("tmo_late_rsp_ignored", sberror_valid_o, 0);
    @(posedge clk_i); #1;
    master_r_valid_i = 1'b0;
    chk("tmo_late_no_data", sbdata_valid_o, 0);
`else
    found = 0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
